riscv_if: RTL and testbench
===========================

Name: riscv_if

Overview:
- Instruction-fetch stage directly upstream of the decoder; supplies its pc and inst inputs.
- Generates sequential fetch PCs and issues requests on a req/gnt + rvalid instruction-memory port.
- Buffers returned instructions in an in-order FIFO and presents {pc, inst, valid} to decode with a ready backpressure.
- Accepts branch/jump redirects from execute: flushes the buffer and discards in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, fetch-buffer entries (power of 2, >=2); also caps outstanding requests.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32 (`InstAddrBus)  fetch address, word aligned
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; in-order, one per granted request, >=1 cycle after gnt
- imem_rdata_i  in  32 (`InstBus)  fetched instruction
- redirect_i  in  1  taken branch/jump from execute
- redirect_pc_i  in  32  redirect target
- valid_o  out  1  pc_o/inst_o hold a valid instruction
- ready_i  in  1  decode consumes head this cycle
- pc_o  out  32  PC of head instruction
- inst_o  out  32  head instruction
- exc_misalign_o  out  1  misaligned redirect target (feature only; tied 0 otherwise)

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC, resp_pc=RESET_PC, outstanding=0, count=0, state=RUN, valid_o=0, pc_o=0, inst_o=32'h0000_0013 (NOP), imem_req_o=0, exc_misalign_o=0.
- Empty buffer: pc_o=0, inst_o=NOP.
- FSM states RUN and DRAIN:
  - RUN: imem_req_o = !redirect_i && (outstanding+count < DEPTH). imem_addr_o=fetch_pc. On req&&gnt: fetch_pc += 4, outstanding++.
  - rvalid in RUN: push {resp_pc, rdata}, resp_pc += 4, outstanding--.
  - DRAIN: imem_req_o=0. Each rvalid is discarded (outstanding--, no push). When outstanding reaches 0, go to RUN on the next edge; requests resume that cycle.
- Credit: outstanding+count is never allowed to exceed DEPTH, so a push never hits a full buffer. Counter width is $clog2(DEPTH+1).
- Pop: when valid_o && ready_i, head advances at the edge. Simultaneous push and pop is allowed; count is unchanged.
- Latency: gnt in cycle N with rvalid in N+1 gives valid_o in N+2. No bypass.
- Redirect (any state), at the edge:
  - buffer cleared (count=0, the pop this cycle is ignored);
  - fetch_pc=resp_pc=redirect_pc_i with bits[1:0] forced 0;
  - an rvalid arriving in the redirect cycle is discarded;
  - remaining outstanding != 0 -> DRAIN, else RUN. Next cycle valid_o=0.
- Redirect while in DRAIN: targets are updated and the FSM stays in DRAIN.
- Wrap: fetch_pc wraps modulo 2^32 with no flag.
- Reset mid-operation: all state returns to reset values immediately; late rvalids after reset are the memory's responsibility (the memory is reset by the same rst).

Optional Feature:
- Macro: RISCV_IF_MISALIGN_EN
- Defined: a redirect with redirect_pc_i[1:0]!=0 sets exc_misalign_o=1 (registered, held) and suppresses all requests until the next aligned redirect, which clears it. The buffer is still flushed.
- Undefined: exc_misalign_o=0 and low bits are silently forced to 0.

Test Plan:
- Reset release, gnt=1, rvalid 1 cycle later, ready=1 -> imem_addr_o=0,4,8,...; valid_o first high 2 cycles after first gnt; pc_o=0,4,8 with matching inst_o.
- ready_i=0 with DEPTH=4 -> exactly 4 requests granted, then imem_req_o=0; raise ready -> pc_o 0,4,8,C in order, then requests resume at 0x10.
- gnt held 0 for 3 cycles -> imem_addr_o stable at 0x0 and imem_req_o stays 1; fetch_pc advances only on gnt.
- Redirect to 0x100 with 2 requests outstanding -> DRAIN, both rvalids dropped, valid_o=0; then RUN with imem_addr_o=0x100 and first valid pc_o=0x100.
- Redirect in the same cycle as rvalid and pop with a full buffer -> buffer empty next cycle, response discarded, no stale pc_o ever presented.
- Assert rst mid-stream -> outputs immediately at reset values, imem_addr_o=RESET_PC after release. With RISCV_IF_MISALIGN_EN, redirect to 0x102 -> exc_misalign_o=1 and no requests until a redirect to 0x200.

Source files
------------

// File: rtl/riscv_if_if.sv
// Instruction-memory fetch bus: req/gnt request channel plus in-order rvalid response channel.
// master = fetch stage, slave = instruction memory.
interface riscv_if_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/riscv_if.sv
// Instruction-fetch stage: sequential fetch, credit-limited in-order buffer, redirect flush/drain.
// Optional macro RISCV_IF_MISALIGN_EN flags misaligned redirect targets and stalls fetch until realigned.
module riscv_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    riscv_if_if.master        imem,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       pc_o,
    output logic [31:0]       inst_o,
    output logic              exc_misalign_o
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t          r_state;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [31:0]     r_buf_pc   [DEPTH];
    logic [31:0]     r_buf_inst [DEPTH];

    logic            w_credit;
    logic            w_req;
    logic            w_grant;
    logic            w_rsp;
    logic            w_push;
    logic            w_pop;
    logic            w_misalign;
    logic [CW-1:0]   w_out_next;
    logic [31:0]     w_target;

    assign w_target = {redirect_pc_i[31:2], 2'b00};

`ifdef RISCV_IF_MISALIGN_EN
    logic r_misalign;

    // Sticky until the next redirect, which either re-arms or clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (redirect_i) begin
            r_misalign <= |redirect_pc_i[1:0];
        end
    end

    assign w_misalign = r_misalign;
`else
    logic w_unused_lowbits;

    assign w_unused_lowbits = ^redirect_pc_i[1:0];
    assign w_misalign       = 1'b0;
`endif

    // Outstanding plus buffered never exceeds DEPTH, so every response has a free slot.
    assign w_credit   = ({1'b0, r_outstanding} + {1'b0, r_count}) < DEPTH_C;
    assign w_req      = !rst && (r_state == RUN) && !redirect_i && w_credit && !w_misalign;
    assign w_grant    = w_req && imem.imem_gnt_i;
    assign w_rsp      = imem.imem_rvalid_i && (r_outstanding != '0);
    assign w_push     = w_rsp && (r_state == RUN) && !redirect_i;
    assign w_pop      = valid_o && ready_i && !redirect_i;
    assign w_out_next = r_outstanding + CW'(w_grant) - CW'(w_rsp);

    assign imem.imem_req_o  = w_req;
    assign imem.imem_addr_o = r_fetch_pc;

    assign valid_o        = (r_count != '0);
    assign pc_o           = valid_o ? r_buf_pc[r_rd_ptr]   : 32'h0;
    assign inst_o         = valid_o ? r_buf_inst[r_rd_ptr] : NOP;
    assign exc_misalign_o = w_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect_i) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_state    <= (w_out_next != '0) ? DRAIN : RUN;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_wr_ptr  <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (r_state == DRAIN && w_out_next == '0) begin
                    r_state <= RUN;
                end
            end
        end
    end

    // Buffer payload carries no reset; valid_o masks stale entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wr_ptr]   <= r_resp_pc;
            r_buf_inst[r_wr_ptr] <= imem.imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_riscv_if.sv
// Bench for riscv_if: memory responder with programmable latency, fetch-address model and
// in-order {pc, inst} scoreboard, plus a per-cycle vector table for the startup sequence.
module tb_riscv_if;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        ready_i = 1'b0;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        exc_misalign_o;

    riscv_if_if bus ();

    riscv_if #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (bus),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .pc_o           (pc_o),
        .inst_o         (inst_o),
        .exc_misalign_o (exc_misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int gcyc; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
    typedef struct {
        logic gnt; logic ready;
        logic req; logic [31:0] addr; logic valid; logic [31:0] pc;
    } vec_t;

    pend_t       pend_q[$];
    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          grants = 0;
    int          rsp_cnt = 0;
    logic [31:0] exp_addr = RESET_PC;
    logic [31:0] last_gaddr = 32'h0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A3C_0F00 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // One clock: sample just after the previous negedge, book-keep, cross posedge, drive responses.
    task automatic tick();
        #1;
        if (!valid_o) begin
            check("empty_pc", pc_o, 32'h0);
            check("empty_inst", inst_o, NOP);
        end else if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL stale_head: got pc %h want no valid", pc_o);
        end else begin
            check("head_pc", pc_o, exp_q[0].pc);
            check("head_inst", inst_o, exp_q[0].inst);
        end
        if (bus.imem_req_o) check("fetch_addr", bus.imem_addr_o, exp_addr);
        if (redirect_i) begin
            exp_q.delete();
            exp_addr = {redirect_pc_i[31:2], 2'b00};
        end else begin
            if (valid_o && ready_i && exp_q.size() > 0) exp_q.delete(0);
            if (bus.imem_req_o && bus.imem_gnt_i) begin
                pend_q.push_back('{bus.imem_addr_o, cyc});
                exp_q.push_back('{bus.imem_addr_o, memf(bus.imem_addr_o)});
                last_gaddr = bus.imem_addr_o;
                exp_addr   = exp_addr + 32'd4;
                grants++;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        redirect_i = 1'b0;
        if (pend_q.size() > 0 && (cyc - pend_q[0].gcyc) >= lat) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = memf(pend_q[0].addr);
            pend_q.delete(0);
            rsp_cnt++;
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic apply_reset();
        rst               = 1'b1;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        ready_i           = 1'b0;
        redirect_i        = 1'b0;
        pend_q.delete();
        exp_q.delete();
        exp_addr = RESET_PC;
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_inst", inst_o, NOP);
        check("rst_req", bus.imem_req_o, 0);
        check("rst_exc", exc_misalign_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.imem_gnt_i = 1'b0;
        ready_i = 1'b1;
        repeat (n) tick();
    endtask

    task automatic wait_valid(input string name, input logic [31:0] want_pc);
        int n;
        n = 0;
        #1;
        while (!valid_o && n < 20) begin
            tick();
            #1;
            n++;
        end
        if (!valid_o) fail_now(name);
        else check(name, pc_o, want_pc);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vt[8];
        int   g0;
        int   rsp0;
        int   n;

        vt[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
        vt[2] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
        vt[3] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
        vt[4] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
        vt[5] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC};
        vt[6] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10};
        vt[7] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b0, 32'h0};

        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        @(negedge clk);
        apply_reset();

        // Startup sequence, 1-cycle memory, decode always ready.
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            bus.imem_gnt_i = vt[i].gnt;
            ready_i        = vt[i].ready;
            #1;
            check($sformatf("vec%0d_req", i), bus.imem_req_o, vt[i].req);
            check($sformatf("vec%0d_addr", i), bus.imem_addr_o, vt[i].addr);
            check($sformatf("vec%0d_valid", i), valid_o, vt[i].valid);
            check($sformatf("vec%0d_pc", i), pc_o, vt[i].pc);
            tick();
        end

        // Backpressure: credit caps grants at DEPTH, then fetch resumes at 0x10.
        apply_reset();
        bus.imem_gnt_i = 1'b1;
        ready_i = 1'b0;
        g0 = grants;
        repeat (10) tick();
        check("credit_grants", grants - g0, 4);
        #1;
        check("credit_req_low", bus.imem_req_o, 0);
        ready_i = 1'b1;
        n = 0;
        while (grants - g0 < 5 && n < 20) begin
            tick();
            n++;
        end
        if (grants - g0 < 5) fail_now("resume_grant");
        else check("resume_addr", last_gaddr, 32'h10);
        idle(4);

        // Grant withheld: address and request hold.
        apply_reset();
        bus.imem_gnt_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("nognt_req", bus.imem_req_o, 1);
            check("nognt_addr", bus.imem_addr_o, RESET_PC);
            tick();
        end
        bus.imem_gnt_i = 1'b1;
        tick();
        #1;
        check("gnt_advance", bus.imem_addr_o, 32'h4);
        idle(4);

        // Redirect with two requests in flight: drain, drop both, restart at target.
        apply_reset();
        lat = 4;
        ready_i = 1'b1;
        bus.imem_gnt_i = 1'b1;
        tick();
        tick();
        rsp0 = rsp_cnt;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        tick();
        n = 0;
        #1;
        while (!bus.imem_req_o && n < 20) begin
            check("drain_valid", valid_o, 0);
            tick();
            #1;
            n++;
        end
        if (!bus.imem_req_o) fail_now("drain_exit");
        check("drain_dropped", rsp_cnt - rsp0, 2);
        check("drain_restart_addr", bus.imem_addr_o, 32'h100);
        lat = 1;
        wait_valid("redirect_first_pc", 32'h100);
        idle(6);

        // Redirect coinciding with rvalid and pop while buffer holds three entries.
        apply_reset();
        lat = 3;
        bus.imem_gnt_i = 1'b1;
        ready_i = 1'b0;
        rsp0 = rsp_cnt;
        n = 0;
        while (rsp_cnt - rsp0 < 4 && n < 30) begin
            tick();
            n++;
        end
        if (rsp_cnt - rsp0 < 4) fail_now("fill_buffer");
        #1;
        check("fill_valid", valid_o, 1);
        check("fill_rvalid", bus.imem_rvalid_i, 1);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h40;
        ready_i = 1'b1;
        tick();
        #1;
        check("flush_valid", valid_o, 0);
        check("flush_pc", pc_o, 32'h0);
        check("flush_inst", inst_o, NOP);
        check("flush_req", bus.imem_req_o, 1);
        check("flush_addr", bus.imem_addr_o, 32'h40);
        lat = 1;
        wait_valid("flush_first_pc", 32'h40);

        // Wrap across 2^32.
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        tick();
        repeat (3) tick();
        check("wrap_last_grant", last_gaddr, 32'h0);
        repeat (4) tick();

        // Reset in the middle of a cycle.
        #2;
        apply_reset();
        #1;
        check("postrst_req", bus.imem_req_o, 1);
        check("postrst_addr", bus.imem_addr_o, RESET_PC);

        // Misaligned redirect target.
        idle(3);
`ifdef RISCV_IF_MISALIGN_EN
        bus.imem_gnt_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h102;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("mis_exc", exc_misalign_o, 1);
            check("mis_req", bus.imem_req_o, 0);
            tick();
        end
        redirect_i = 1'b1;
        redirect_pc_i = 32'h200;
        tick();
        #1;
        check("realign_exc", exc_misalign_o, 0);
        check("realign_req", bus.imem_req_o, 1);
        check("realign_addr", bus.imem_addr_o, 32'h200);
        wait_valid("realign_first_pc", 32'h200);
`else
        bus.imem_gnt_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h103;
        tick();
        #1;
        check("align_exc", exc_misalign_o, 0);
        check("align_req", bus.imem_req_o, 1);
        check("align_addr", bus.imem_addr_o, 32'h100);
        wait_valid("align_first_pc", 32'h100);
`endif
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
